// File: rtl/key_event_array.sv
// key_event_array
//
// Multi-channel push-button front end. Each channel synchronises its raw key
// level, debounces it with a stability counter, emits one-cycle press/release
// pulses on accepted level changes, and optionally auto-repeats the press
// pulse while the key is held (initial delay, then a fixed repeat period).
//
// Ports:
//   clk          in   1         rising-edge clock (25 MHz VGA domain)
//   reset_n      in   1         asynchronous active-low reset
//   key_raw      in   CHANNELS  raw asynchronous button levels
//   key_level    out  CHANNELS  debounced level, 1 = pressed
//   key_press    out  CHANNELS  1-cycle pulse on accepted press and on each repeat
//   key_repeat   out  CHANNELS  high with key_press when that pulse is a repeat
//   key_release  out  CHANNELS  1-cycle pulse on accepted release
//
// All outputs are registered; there is no combinational path from key_raw.

module key_event_array #(
    parameter int unsigned         CHANNELS        = 4,
    parameter int unsigned         SYNC_STAGES     = 2,
    parameter int unsigned         DEBOUNCE_CYCLES = 250000,
    parameter int unsigned         REPEAT_DELAY    = 5000000,
    parameter int unsigned         REPEAT_RATE     = 1250000,
    parameter logic [CHANNELS-1:0] REPEAT_MASK     = {CHANNELS{1'b1}},
    parameter bit                  ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] key_raw,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] key_press,
    output logic [CHANNELS-1:0] key_repeat,
    output logic [CHANNELS-1:0] key_release
);

    // Counter widths sized to the largest value each counter holds, minimum 1 bit.
    localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DebLast   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DelayLast = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RateLast  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } state_e;

    // Synchroniser
    logic [CHANNELS-1:0] w_k;
    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];

    // Debouncer
    logic [DW-1:0]       r_dcnt   [CHANNELS];
    logic [DW-1:0]       w_dcnt_d [CHANNELS];
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] w_level_d;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;

    // Repeat FSM
    state_e              r_state   [CHANNELS];
    state_e              w_state_d [CHANNELS];
    logic [RW-1:0]       r_rcnt    [CHANNELS];
    logic [RW-1:0]       w_rcnt_d  [CHANNELS];
    logic [CHANNELS-1:0] r_press;
    logic [CHANNELS-1:0] w_press_d;
    logic [CHANNELS-1:0] r_repeat;
    logic [CHANNELS-1:0] w_repeat_d;
    logic [CHANNELS-1:0] r_release;
    logic [CHANNELS-1:0] w_release_d;

    // Polarity is normalised before the synchroniser so its reset value of 0
    // always means "not pressed".
    assign w_k = key_raw ^ {CHANNELS{ACTIVE_LOW}};
    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_k;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Debounce: count consecutive cycles the synchronised level differs from the
    // accepted level; any bounce back clears the count.
    always_comb begin
        w_level_d = r_level;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_dcnt_d[c] = '0;
            if (w_s[c] != r_level[c]) begin
                if (r_dcnt[c] == DebLast) begin
                    w_level_d[c] = w_s[c];
                end else begin
                    w_dcnt_d[c] = r_dcnt[c] + 1'b1;
                end
            end
        end
    end

    // Edges are taken from the next-state level so the pulse registers on the
    // same edge as the level change.
    assign w_rise = ~r_level & w_level_d;
    assign w_fall = r_level & ~w_level_d;

    always_comb begin
        w_press_d   = '0;
        w_repeat_d  = '0;
        w_release_d = '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            w_state_d[c] = r_state[c];
            w_rcnt_d[c]  = r_rcnt[c];
            if (w_fall[c]) begin
                // Release wins over a repeat falling due on the same edge.
                w_release_d[c] = 1'b1;
                w_rcnt_d[c]    = '0;
                w_state_d[c]   = StIdle;
            end else begin
                case (r_state[c])
                    StIdle: begin
                        if (w_rise[c]) begin
                            w_press_d[c] = 1'b1;
                            w_rcnt_d[c]  = '0;
                            w_state_d[c] = StDelay;
                        end
                    end
                    StDelay: begin
                        // Masked channels park here until release.
                        if (REPEAT_MASK[c]) begin
                            if (r_rcnt[c] == DelayLast) begin
                                w_press_d[c]  = 1'b1;
                                w_repeat_d[c] = 1'b1;
                                w_rcnt_d[c]   = '0;
                                w_state_d[c]  = StRepeat;
                            end else begin
                                w_rcnt_d[c] = r_rcnt[c] + 1'b1;
                            end
                        end
                    end
                    StRepeat: begin
                        if (r_rcnt[c] == RateLast) begin
                            w_press_d[c]  = 1'b1;
                            w_repeat_d[c] = 1'b1;
                            w_rcnt_d[c]   = '0;
                        end else begin
                            w_rcnt_d[c] = r_rcnt[c] + 1'b1;
                        end
                    end
                    default: begin
                        w_rcnt_d[c]  = '0;
                        w_state_d[c] = StIdle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                r_dcnt[c]  <= '0;
                r_rcnt[c]  <= '0;
                r_state[c] <= StIdle;
            end
            r_level   <= '0;
            r_press   <= '0;
            r_repeat  <= '0;
            r_release <= '0;
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                r_dcnt[c]  <= w_dcnt_d[c];
                r_rcnt[c]  <= w_rcnt_d[c];
                r_state[c] <= w_state_d[c];
            end
            r_level   <= w_level_d;
            r_press   <= w_press_d;
            r_repeat  <= w_repeat_d;
            r_release <= w_release_d;
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_repeat  = r_repeat;
    assign key_release = r_release;

endmodule
